opfetch: RTL and testbench

//  Operand-fetch stage: the reader side of the 2R/1W register file. Accepts decoded instructions
//  (rs1/rs2 + payload) over valid/ready, drives the register-file read addresses, absorbs its
//  1-cycle registered read latency, and presents operands to execute over valid/ready.

---
 rtl/ecap5_dproc_pkg.sv | 16 +
 rtl/opfetch_fwd_sel.sv | 34 +++
 rtl/opfetch.sv | 162 ++++++++++++++++
 tb/tb_opfetch.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ecap5_dproc_pkg.sv
// Shared datapath constants and types for the ecap5 processor pipeline stages.
package ecap5_dproc_pkg;

    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // A write only forwards to a nonzero source index; x0 is hardwired to zero.
    function automatic logic fwd_hit(input logic vld, input reg_addr_t waddr, input reg_addr_t rs);
        return vld && (waddr == rs) && (rs != REG_ZERO);
    endfunction

endpackage

// File: rtl/opfetch_fwd_sel.sv
// Operand select for one source: x0, live writeback, captured writeback, else register-file data.
// Forwarding inputs exist only when OPFETCH_BYPASS_EN is defined.
module opfetch_fwd_sel
    import ecap5_dproc_pkg::*;
(
    input  logic [REG_ADDR_WIDTH-1:0] rs_i,
    input  logic [XLEN-1:0]           rdata_i,
    output logic [XLEN-1:0]           op_o
`ifdef OPFETCH_BYPASS_EN
    ,
    input  logic                      live_vld_i,
    input  logic [REG_ADDR_WIDTH-1:0] live_addr_i,
    input  logic [XLEN-1:0]           live_data_i,
    input  logic                      cap_vld_i,
    input  logic [REG_ADDR_WIDTH-1:0] cap_addr_i,
    input  logic [XLEN-1:0]           cap_data_i
`endif
);

    always_comb begin
        op_o = rdata_i;
        if (rs_i == REG_ZERO) begin
            op_o = '0;
        end
`ifdef OPFETCH_BYPASS_EN
        else if (fwd_hit(live_vld_i, live_addr_i, rs_i)) begin
            op_o = live_data_i;
        end else if (fwd_hit(cap_vld_i, cap_addr_i, rs_i)) begin
            op_o = cap_data_i;
        end
`endif
    end

endmodule

// File: rtl/opfetch.sv
// Operand-fetch stage: issues register-file reads, absorbs the 1-cycle read latency and
// hands operands to execute. Writeback snooping is enabled by OPFETCH_BYPASS_EN.
module opfetch
    import ecap5_dproc_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = 32
)
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      input_valid_i,
    output logic                      input_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_i,
    input  logic [PAYLOAD_WIDTH-1:0]  payload_i,
    output logic [REG_ADDR_WIDTH-1:0] raddr1_o,
    output logic [REG_ADDR_WIDTH-1:0] raddr2_o,
    input  logic [XLEN-1:0]           rdata1_i,
    input  logic [XLEN-1:0]           rdata2_i,
    input  logic                      wb_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_waddr_i,
    input  logic [XLEN-1:0]           wb_wdata_i,
    output logic                      output_valid_o,
    input  logic                      output_ready_i,
    output logic [XLEN-1:0]           op1_o,
    output logic [XLEN-1:0]           op2_o,
    output logic [PAYLOAD_WIDTH-1:0]  payload_o
);

    logic                     s1_valid_q, s1_valid_d;
    reg_addr_t                s1_rs1_q, s1_rs1_d, s1_rs2_q, s1_rs2_d;
    logic [PAYLOAD_WIDTH-1:0] s1_payload_q, s1_payload_d;
    logic                     out_valid_q, out_valid_d;
    logic [XLEN-1:0]          op1_q, op1_d, op2_q, op2_d;
    logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;
    logic [XLEN-1:0]          sel_op1, sel_op2;
    logic                     out_free, accept, s1_xfer;

    assign out_free      = !out_valid_q || output_ready_i;
    assign input_ready_o = !rst_i && (!s1_valid_q || out_free);
    assign accept        = input_valid_i && input_ready_o;
    assign s1_xfer       = s1_valid_q && out_free;

    // While S1 is stalled its own indices are re-read so rdata always matches S1.
    assign raddr1_o = accept ? rs1_i : s1_rs1_q;
    assign raddr2_o = accept ? rs2_i : s1_rs2_q;

`ifdef OPFETCH_BYPASS_EN
    // Covers a write landing on the same edge as the read, which returns the old value.
    logic      cap_vld_q;
    reg_addr_t cap_addr_q, out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
    logic [XLEN-1:0] cap_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap_vld_q  <= 1'b0;
            cap_addr_q <= REG_ZERO;
            cap_data_q <= '0;
            out_rs1_q  <= REG_ZERO;
            out_rs2_q  <= REG_ZERO;
        end else begin
            cap_vld_q  <= wb_write_i && (wb_waddr_i != REG_ZERO);
            cap_addr_q <= wb_waddr_i;
            cap_data_q <= wb_wdata_i;
            out_rs1_q  <= out_rs1_d;
            out_rs2_q  <= out_rs2_d;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_write_i, wb_waddr_i, wb_wdata_i};
`endif

    opfetch_fwd_sel u_sel1 (
        .rs_i(s1_rs1_q), .rdata_i(rdata1_i), .op_o(sel_op1)
`ifdef OPFETCH_BYPASS_EN
        , .live_vld_i(wb_write_i), .live_addr_i(wb_waddr_i), .live_data_i(wb_wdata_i)
        , .cap_vld_i(cap_vld_q), .cap_addr_i(cap_addr_q), .cap_data_i(cap_data_q)
`endif
    );

    opfetch_fwd_sel u_sel2 (
        .rs_i(s1_rs2_q), .rdata_i(rdata2_i), .op_o(sel_op2)
`ifdef OPFETCH_BYPASS_EN
        , .live_vld_i(wb_write_i), .live_addr_i(wb_waddr_i), .live_data_i(wb_wdata_i)
        , .cap_vld_i(cap_vld_q), .cap_addr_i(cap_addr_q), .cap_data_i(cap_data_q)
`endif
    );

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_rs1_d     = s1_rs1_q;
        s1_rs2_d     = s1_rs2_q;
        s1_payload_d = s1_payload_q;
        if (accept) begin
            s1_valid_d   = 1'b1;
            s1_rs1_d     = rs1_i;
            s1_rs2_d     = rs2_i;
            s1_payload_d = payload_i;
        end else if (s1_xfer) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        payload_d   = payload_q;
`ifdef OPFETCH_BYPASS_EN
        out_rs1_d   = out_rs1_q;
        out_rs2_d   = out_rs2_q;
`endif
        if (s1_xfer) begin
            out_valid_d = 1'b1;
            op1_d       = sel_op1;
            op2_d       = sel_op2;
            payload_d   = s1_payload_q;
`ifdef OPFETCH_BYPASS_EN
            out_rs1_d   = s1_rs1_q;
            out_rs2_d   = s1_rs2_q;
`endif
        end else if (output_ready_i) begin
            out_valid_d = 1'b0;
        end
`ifdef OPFETCH_BYPASS_EN
        else if (out_valid_q) begin
            // Held operands track writes so they are current whenever execute takes them.
            if (fwd_hit(wb_write_i, wb_waddr_i, out_rs1_q)) op1_d = wb_wdata_i;
            if (fwd_hit(wb_write_i, wb_waddr_i, out_rs2_q)) op2_d = wb_wdata_i;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q   <= 1'b0;
            s1_rs1_q     <= REG_ZERO;
            s1_rs2_q     <= REG_ZERO;
            s1_payload_q <= '0;
            out_valid_q  <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            payload_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_rs1_q     <= s1_rs1_d;
            s1_rs2_q     <= s1_rs2_d;
            s1_payload_q <= s1_payload_d;
            out_valid_q  <= out_valid_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            payload_q    <= payload_d;
        end
    end

    assign output_valid_o = out_valid_q;
    assign op1_o          = op1_q;
    assign op2_o          = op2_q;
    assign payload_o      = payload_q;

endmodule

// File: tb/tb_opfetch.sv
// Scoreboard bench for opfetch with a registered-read 2R/1W register-file model.
module tb_opfetch;

    localparam bit BYP =
`ifdef OPFETCH_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] pl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        input_valid = 1'b0, input_ready;
    logic [4:0]  rs1 = '0, rs2 = '0, raddr1, raddr2;
    logic [31:0] payload = '0, rdata1, rdata2;
    logic        wb_write = 1'b0;
    logic [4:0]  wb_waddr = '0;
    logic [31:0] wb_wdata = '0;
    logic        output_valid, output_ready = 1'b1;
    logic [31:0] op1, op2, payload_out;
    logic [31:0] rf [32];

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    opfetch #(.PAYLOAD_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .input_valid_i(input_valid), .input_ready_o(input_ready),
        .rs1_i(rs1), .rs2_i(rs2), .payload_i(payload),
        .raddr1_o(raddr1), .raddr2_o(raddr2),
        .rdata1_i(rdata1), .rdata2_i(rdata2),
        .wb_write_i(wb_write), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
        .output_valid_o(output_valid), .output_ready_i(output_ready),
        .op1_o(op1), .op2_o(op2), .payload_o(payload_out)
    );

    // Reads sample the address at the edge and see the pre-write value.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            rdata1 <= rf[raddr1];
            rdata2 <= rf[raddr2];
            if (wb_write && wb_waddr != 5'd0) rf[wb_waddr] <= wb_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_pulse(input logic [4:0] a, input logic [31:0] d);
        wb_write = 1'b1; wb_waddr = a; wb_wdata = d;
        step();
        wb_write = 1'b0;
    endtask

    // Drives one instruction; accept is decided at the negedge, where inputs are stable.
    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] pl,
                         input logic [31:0] e1, input logic [31:0] e2);
        input_valid = 1'b1; rs1 = r1; rs2 = r2; payload = pl;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (input_ready) begin
                @(posedge clk);
                sbq.push_back('{op1: e1, op2: e2, pl: pl});
                #1;
                input_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL issue_timeout: got input_ready_o=0 for 20 cycles expected 1, payload %h", pl);
        input_valid = 1'b0;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst && output_valid && output_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got payload %h expected none", payload_out);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("op1", op1, e.op1);
                        chk("op2", op2, e.op2);
                        chk("payload", payload_out, e.pl);
                    end
                end
            end
        join_none

        // Reset held with a valid upstream request.
        input_valid = 1'b1; rs1 = 5'd3; rs2 = 5'd4; payload = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_out_valid", {31'd0, output_valid}, 32'd0);
            chk("rst_op1", op1, 32'd0);
            chk("rst_op2", op2, 32'd0);
            chk("rst_in_ready", {31'd0, input_ready}, 32'd0);
        end
        chk("rst_payload", payload_out, 32'd0);
        input_valid = 1'b0;
        rst = 1'b0;
        step();

        wb_pulse(5'd5, 32'h11);
        wb_pulse(5'd6, 32'h22);
        wb_pulse(5'd7, 32'h33);
        step();

        // Plain read and 2-cycle latency.
        issue(5'd5, 5'd6, 32'h100, 32'h11, 32'h22);
        chk("lat_s1", {31'd0, output_valid}, 32'd0);
        step();
        chk("lat_out", {31'd0, output_valid}, 32'd1);
        repeat (3) step();

        // x0 with a concurrent write to x0.
        wb_write = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFFFF;
        issue(5'd0, 5'd5, 32'h101, 32'h0, 32'h11);
        wb_write = 1'b0;
        repeat (3) step();

        // Write in the accept cycle, then a write in the S1 cycle.
        wb_write = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'hAA;
        issue(5'd5, 5'd6, 32'h102, BYP ? 32'hAA : 32'h11, 32'h22);
        wb_write = 1'b0;
        repeat (3) step();
        issue(5'd5, 5'd6, 32'h103, BYP ? 32'hBB : 32'hAA, 32'h22);
        wb_pulse(5'd5, 32'hBB);
        repeat (3) step();
        wb_pulse(5'd5, 32'h11);
        step();

        // Backpressure: execute stalls 5 cycles under three back-to-back instructions.
        output_ready = 1'b0;
        fork
            begin
                issue(5'd5, 5'd6, 32'h200, 32'h11, 32'h22);
                issue(5'd6, 5'd5, 32'h201, 32'h22, 32'h11);
                issue(5'd0, 5'd7, 32'h202, 32'h0, 32'h33);
            end
            begin
                step();
                step();
                chk("full_in_ready", {31'd0, input_ready}, 32'd0);
                repeat (3) step();
                chk("bp_out_valid", {31'd0, output_valid}, 32'd1);
                chk("bp_hold_payload", payload_out, 32'h200);
                output_ready = 1'b1;
            end
        join
        repeat (6) step();

        // Held OUT snoops a write to its rs1.
        output_ready = 1'b0;
        issue(5'd7, 5'd6, 32'h300, BYP ? 32'h55 : 32'h33, 32'h22);
        step();
        chk("stall_valid", {31'd0, output_valid}, 32'd1);
        chk("stall_op1_pre", op1, 32'h33);
        wb_pulse(5'd7, 32'h55);
        chk("stall_snoop_op1", op1, BYP ? 32'h55 : 32'h33);
        chk("stall_op2", op2, 32'h22);
        chk("stall_payload", payload_out, 32'h300);
        output_ready = 1'b1;
        repeat (4) step();

        chk("sb_empty", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
